irq_gateway: RTL

IRQ_GATEWAY -- requirements
Module: irq_gateway

---
 rtl/irq_gateway.sv | 120 ++++++++++++
 1 files changed

// File: rtl/irq_gateway.sv
// Interrupt gateway: conditions raw asynchronous device interrupts (polarity, synchroniser,
// optional glitch filter) and presents level or edge-pending requests to a PLIC.
module irq_gateway #(
  parameter int                 NumIrqs       = 32,
  parameter int                 SyncStages    = 2,
  parameter int                 FilterCycles  = 0,
  parameter logic [NumIrqs-1:0] EdgeMask      = '0,
  parameter logic [NumIrqs-1:0] ActiveLowMask = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumIrqs-1:0] irq_i,
  input  logic [NumIrqs-1:0] enable_i,
  input  logic [NumIrqs-1:0] ack_i,
  output logic [NumIrqs-1:0] interrupts_o,
  output logic [NumIrqs-1:0] edge_trigger_o,
  output logic [NumIrqs-1:0] missed_o
);

  // Line 0 is reserved and never produces a request.
  localparam logic [NumIrqs-1:0] LineMask  = {{(NumIrqs-1){1'b1}}, 1'b0};
  localparam logic [NumIrqs-1:0] EdgeLines = EdgeMask & LineMask;

  logic [NumIrqs-1:0] w_asserted;
  logic [NumIrqs-1:0] w_sync;
  logic [NumIrqs-1:0] w_filt;
  logic [NumIrqs-1:0] w_rise;
  logic [NumIrqs-1:0] w_qual;
  logic [NumIrqs-1:0] w_pend_nxt;
  logic [NumIrqs-1:0] w_missed_nxt;
  logic [NumIrqs-1:0] w_int_nxt;

  logic [NumIrqs-1:0] r_sync [SyncStages];
  logic [NumIrqs-1:0] r_filt_d;
  logic [NumIrqs-1:0] r_pend;
  logic [NumIrqs-1:0] r_missed;
  logic [NumIrqs-1:0] r_int;

  assign w_asserted = irq_i ^ ActiveLowMask;

  // Synchroniser stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SyncStages; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= w_asserted;
      for (int s = 1; s < SyncStages; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SyncStages-1];

  // Glitch-filter stage
  generate
    if (FilterCycles == 0) begin : g_nofilt
      assign w_filt = w_sync;
    end else begin : g_filt
      localparam int CntW = $clog2(FilterCycles + 1);
      // The counter never stores N: the edge that would reach N loads the filtered value.
      localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

      logic [CntW-1:0]    r_cnt [NumIrqs];
      logic [NumIrqs-1:0] r_filt;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_filt <= '0;
          for (int i = 0; i < NumIrqs; i++) begin
            r_cnt[i] <= '0;
          end
        end else begin
          for (int i = 0; i < NumIrqs; i++) begin
            if (w_sync[i] == r_filt[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == CntLast) begin
              r_filt[i] <= w_sync[i];
              r_cnt[i]  <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + 1'b1;
            end
          end
        end
      end

      assign w_filt = r_filt;
    end
  endgenerate

  // Edge/level qualification stage
  assign w_rise       = w_filt & ~r_filt_d;
  assign w_qual       = w_rise & enable_i & EdgeLines;
  // A new edge wins over a simultaneous ack, and ack always clears missed.
  assign w_pend_nxt   = EdgeLines & (w_qual | (r_pend & ~ack_i));
  assign w_missed_nxt = EdgeLines & ~ack_i & (r_missed | (w_qual & r_pend));
  assign w_int_nxt    = LineMask & enable_i &
                        ((EdgeMask & w_pend_nxt) | (~EdgeMask & w_filt));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_filt_d <= '0;
      r_pend   <= '0;
      r_missed <= '0;
      r_int    <= '0;
    end else begin
      r_filt_d <= w_filt;
      r_pend   <= w_pend_nxt;
      r_missed <= w_missed_nxt;
      r_int    <= w_int_nxt;
    end
  end

  assign interrupts_o   = r_int;
  assign missed_o       = r_missed;
  assign edge_trigger_o = EdgeLines;

endmodule
